// File: rtl/sap1_pkg.sv
// sap1_pkg: shared opcodes, T-state encoding and control-word bit indices for SAP-1
package sap1_pkg;

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    typedef enum logic [2:0] {
        T1 = 3'd0,
        T2 = 3'd1,
        T3 = 3'd2,
        T4 = 3'd3,
        T5 = 3'd4,
        T6 = 3'd5
    } t_state_e;

    localparam int CW_W = 12;

    typedef enum logic [3:0] {
        CW_PC_INC,
        CW_PC_EN,
        CW_MAR_LD,
        CW_RAM_EN,
        CW_IR_LD,
        CW_IR_EN,
        CW_A_LD,
        CW_A_EN,
        CW_B_LD,
        CW_ALU_EN,
        CW_ALU_SUB,
        CW_OUT_LD
    } cw_bit_e;

endpackage

// File: rtl/sap1_ring_counter.sv
// sap1_ring_counter: T1..T6 sequencer that wraps at T6 and holds while frozen
module sap1_ring_counter
    import sap1_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       freeze,
    output logic [2:0] tstate
);

    t_state_e state;
    t_state_e state_next;

    assign tstate = state;

    // T-state register; reset always returns to T1
    always_ff @(posedge clk) begin
        if (rst) state <= T1;
        else     state <= state_next;
    end

    // advance one T-state per clock, wrapping T6 to T1, unless frozen
    always_comb begin
        state_next = state;
        if (!freeze) state_next = (state == T6) ? T1 : t_state_e'(state + 3'd1);
    end

endmodule

// File: rtl/sap1_controller.sv
// sap1_controller: SAP-1 fetch/execute control sequencer with HLT latch
module sap1_controller
    import sap1_pkg::*;
#(
    parameter int OPC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [OPC_W-1:0] opcode,
    output logic             pc_inc,
    output logic             pc_en,
    output logic             mar_ld,
    output logic             ram_en,
    output logic             ir_ld,
    output logic             ir_en,
    output logic             a_ld,
    output logic             a_en,
    output logic             b_ld,
    output logic             alu_en,
    output logic             alu_sub,
    output logic             out_ld,
    output logic             halted,
    output logic [2:0]       tstate
);

    logic [CW_W-1:0] cw;
    logic            is_mem;
    logic            is_alu;

    sap1_ring_counter u_ring (
        .clk    (clk),
        .rst    (rst),
        .freeze (halted),
        .tstate (tstate)
    );

    // HLT latches on the edge ending T4; the counter moves to T5 on that same edge and then freezes
    always_ff @(posedge clk) begin
        if (rst)                                         halted <= 1'b0;
        else if (!halted && tstate == T4 && opcode == OP_HLT) halted <= 1'b1;
    end

    assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB);
    assign is_mem = is_alu || (opcode == OP_LDA);

    // control word decode from T-state and opcode; a halted machine drives nothing
    always_comb begin
        cw = '0;
        if (!halted) begin
            case (tstate)
                T1: begin
                    cw[CW_PC_EN]  = 1'b1;
                    cw[CW_MAR_LD] = 1'b1;
                end
                T2: cw[CW_PC_INC] = 1'b1;
                T3: begin
                    cw[CW_RAM_EN] = 1'b1;
                    cw[CW_IR_LD]  = 1'b1;
                end
                T4: begin
                    cw[CW_IR_EN]  = is_mem;
                    cw[CW_MAR_LD] = is_mem;
                    cw[CW_A_EN]   = (opcode == OP_OUT);
                    cw[CW_OUT_LD] = (opcode == OP_OUT);
                end
                T5: begin
                    cw[CW_RAM_EN] = is_mem;
                    cw[CW_A_LD]   = (opcode == OP_LDA);
                    cw[CW_B_LD]   = is_alu;
                end
                T6: begin
                    cw[CW_ALU_EN]  = is_alu;
                    cw[CW_A_LD]    = is_alu;
                    cw[CW_ALU_SUB] = (opcode == OP_SUB);
                end
                default: ;
            endcase
        end
    end

    assign pc_inc  = cw[CW_PC_INC];
    assign pc_en   = cw[CW_PC_EN];
    assign mar_ld  = cw[CW_MAR_LD];
    assign ram_en  = cw[CW_RAM_EN];
    assign ir_ld   = cw[CW_IR_LD];
    assign ir_en   = cw[CW_IR_EN];
    assign a_ld    = cw[CW_A_LD];
    assign a_en    = cw[CW_A_EN];
    assign b_ld    = cw[CW_B_LD];
    assign alu_en  = cw[CW_ALU_EN];
    assign alu_sub = cw[CW_ALU_SUB];
    assign out_ld  = cw[CW_OUT_LD];

endmodule

// File: tb/tb_sap1_controller.sv
// tb_sap1_controller: self-checking bench against a micro-op table model of SAP-1 control
module tb_sap1_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] opcode;
    logic       pc_inc, pc_en, mar_ld, ram_en, ir_ld, ir_en;
    logic       a_ld, a_en, b_ld, alu_en, alu_sub, out_ld, halted;
    logic [2:0] tstate;
    logic [15:0] obs;

    int n_chk  = 0;
    int n_fail = 0;
    int m_step = 0;
    bit m_halt = 1'b0;

    localparam logic [11:0] M_PC_INC  = 12'b1000_0000_0000;
    localparam logic [11:0] M_PC_EN   = 12'b0100_0000_0000;
    localparam logic [11:0] M_MAR_LD  = 12'b0010_0000_0000;
    localparam logic [11:0] M_RAM_EN  = 12'b0001_0000_0000;
    localparam logic [11:0] M_IR_LD   = 12'b0000_1000_0000;
    localparam logic [11:0] M_IR_EN   = 12'b0000_0100_0000;
    localparam logic [11:0] M_A_LD    = 12'b0000_0010_0000;
    localparam logic [11:0] M_A_EN    = 12'b0000_0001_0000;
    localparam logic [11:0] M_B_LD    = 12'b0000_0000_1000;
    localparam logic [11:0] M_ALU_EN  = 12'b0000_0000_0100;
    localparam logic [11:0] M_ALU_SUB = 12'b0000_0000_0010;
    localparam logic [11:0] M_OUT_LD  = 12'b0000_0000_0001;

    sap1_controller #(.OPC_W(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .opcode  (opcode),
        .pc_inc  (pc_inc),
        .pc_en   (pc_en),
        .mar_ld  (mar_ld),
        .ram_en  (ram_en),
        .ir_ld   (ir_ld),
        .ir_en   (ir_en),
        .a_ld    (a_ld),
        .a_en    (a_en),
        .b_ld    (b_ld),
        .alu_en  (alu_en),
        .alu_sub (alu_sub),
        .out_ld  (out_ld),
        .halted  (halted),
        .tstate  (tstate)
    );

    always #5 clk = ~clk;

    assign obs = {halted, tstate, pc_inc, pc_en, mar_ld, ram_en, ir_ld, ir_en,
                  a_ld, a_en, b_ld, alu_en, alu_sub, out_ld};

    // micro-op table per instruction step, packed as {halted, tstate, strobes}
    function automatic logic [15:0] exp_all(int s, logic [3:0] op, bit h);
        logic [11:0] w [6];
        w[0] = M_PC_EN | M_MAR_LD;
        w[1] = M_PC_INC;
        w[2] = M_RAM_EN | M_IR_LD;
        w[3] = '0;
        w[4] = '0;
        w[5] = '0;
        if (op == 4'd0 || op == 4'd1 || op == 4'd2) begin
            w[3] = M_IR_EN | M_MAR_LD;
            w[4] = M_RAM_EN | ((op == 4'd0) ? M_A_LD : M_B_LD);
            if (op != 4'd0) w[5] = M_ALU_EN | M_A_LD | ((op == 4'd2) ? M_ALU_SUB : 12'h0);
        end else if (op == 4'd14) begin
            w[3] = M_A_EN | M_OUT_LD;
        end
        return {h, 3'(s), h ? 12'h000 : w[s]};
    endfunction

    // one clock: the model consumes the inputs present at the edge, then outputs settle
    task automatic tick();
        bit         r;
        logic [3:0] o;
        r = rst;
        o = opcode;
        @(posedge clk);
        if (r) begin
            m_step = 0;
            m_halt = 1'b0;
        end else if (!m_halt) begin
            if (m_step == 3 && o == 4'hF) m_halt = 1'b1;
            m_step = (m_step + 1) % 6;
        end
        #1;
    endtask

    task automatic align();
        for (int i = 0; i < 6 && m_step != 0; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        opcode = 4'h0;
        tick();
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs !== exp_all(m_step, opcode, m_halt)) begin
                n_fail++;
                $display("FAIL reset_fetch step %0d: got %h expected %h", i, obs, exp_all(m_step, opcode, m_halt));
            end
            tick();
        end
    endtask

    task automatic test_lda_add();
        logic [3:0] ops [2] = '{4'h0, 4'h1};
        align();
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 6; i++) begin
                n_chk++;
                if (obs !== exp_all(m_step, opcode, m_halt)) begin
                    n_fail++;
                    $display("FAIL lda_add op %h step %0d: got %h expected %h", opcode, i, obs, exp_all(m_step, opcode, m_halt));
                end
                tick();
            end
        end
    endtask

    task automatic test_sub_out();
        logic [3:0] ops [2] = '{4'h2, 4'hE};
        align();
        for (int k = 0; k < 2; k++) begin
            opcode = ops[k];
            for (int i = 0; i < 6; i++) begin
                n_chk++;
                if (obs !== exp_all(m_step, opcode, m_halt)) begin
                    n_fail++;
                    $display("FAIL sub_out op %h step %0d: got %h expected %h", opcode, i, obs, exp_all(m_step, opcode, m_halt));
                end
                tick();
            end
        end
    endtask

    task automatic test_hlt();
        align();
        opcode = 4'hF;
        for (int i = 0; i < 4; i++) tick();
        n_chk++;
        if (halted !== 1'b1 || tstate !== 3'd4) begin
            n_fail++;
            $display("FAIL hlt_entry: got halted=%b tstate=%0d expected halted=1 tstate=4", halted, tstate);
        end
        for (int i = 0; i < 20; i++) begin
            opcode = 4'($urandom_range(0, 15));
            n_chk++;
            if (obs !== exp_all(m_step, opcode, m_halt)) begin
                n_fail++;
                $display("FAIL hlt_hold cycle %0d: got %h expected %h", i, obs, exp_all(m_step, opcode, m_halt));
            end
            tick();
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        opcode = 4'h5;
        for (int i = 0; i < 3; i++) begin
            n_chk++;
            if (obs !== exp_all(m_step, opcode, m_halt)) begin
                n_fail++;
                $display("FAIL hlt_release step %0d: got %h expected %h", i, obs, exp_all(m_step, opcode, m_halt));
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        align();
        opcode = 4'h1;
        for (int i = 0; i < 4; i++) tick();
        n_chk++;
        if (obs !== exp_all(m_step, opcode, m_halt)) begin
            n_fail++;
            $display("FAIL reset_mid T5: got %h expected %h", obs, exp_all(m_step, opcode, m_halt));
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_chk++;
        if (obs !== exp_all(m_step, opcode, m_halt) || a_ld !== 1'b0 || alu_en !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid after: got %h expected %h", obs, exp_all(m_step, opcode, m_halt));
        end
    endtask

    task automatic test_throughput();
        int pulses = 0;
        int last = -1;
        align();
        opcode = 4'h5;
        for (int c = 0; c < 96; c++) begin
            n_chk++;
            if (obs !== exp_all(m_step, opcode, m_halt)) begin
                n_fail++;
                $display("FAIL throughput cycle %0d: got %h expected %h", c, obs, exp_all(m_step, opcode, m_halt));
            end
            if (pc_inc === 1'b1) begin
                n_chk++;
                if (last >= 0 && c - last !== 6) begin
                    n_fail++;
                    $display("FAIL throughput spacing: got %0d expected 6", c - last);
                end
                pulses++;
                last = c;
            end
            tick();
        end
        n_chk++;
        if (pulses !== 16) begin
            n_fail++;
            $display("FAIL throughput count: got %0d expected 16", pulses);
        end
    endtask

    task automatic test_random();
        align();
        for (int k = 0; k < 30; k++) begin
            opcode = 4'($urandom_range(0, 14));
            for (int i = 0; i < 6; i++) begin
                n_chk++;
                if (obs !== exp_all(m_step, opcode, m_halt)) begin
                    n_fail++;
                    $display("FAIL random op %h step %0d: got %h expected %h", opcode, i, obs, exp_all(m_step, opcode, m_halt));
                end
                tick();
            end
        end
    endtask

    initial begin
        test_reset();
        test_lda_add();
        test_sub_out();
        test_hlt();
        test_reset_mid();
        test_throughput();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/sap1_controller.md
# sap1_controller

Control sequencer for the SAP-1 datapath. Drives the program counter's `inc` input and every other load/enable strobe on the W-bus through a fixed six-state (T1–T6) fetch/execute cycle. Decodes the opcode nibble from the instruction register. A T-state ring counter advances on every clock edge, and HLT freezes the machine until reset.

## Interface

Parameters:
- `OPC_W`, default 4: opcode width. Fixed at 4 for SAP-1.

Ports:
- `clk` input, 1: system clock. All state changes occur on the rising edge.
- `rst` input, 1: synchronous, active-high reset.
- `opcode` input, `OPC_W`: upper nibble of the IR. Meaningful only in T4–T6.
- `pc_inc` output, 1: PC increment. Connects to the PC `inc` port.
- `pc_en` output, 1: PC drives the bus.
- `mar_ld` output, 1: load MAR from the bus.
- `ram_en` output, 1: RAM drives the bus.
- `ir_ld` output, 1: load IR from the bus.
- `ir_en` output, 1: IR low nibble (operand address) drives the bus.
- `a_ld` output, 1: load accumulator A.
- `a_en` output, 1: A drives the bus.
- `b_ld` output, 1: load register B.
- `alu_en` output, 1: ALU result drives the bus.
- `alu_sub` output, 1: ALU subtract select (0 = add).
- `out_ld` output, 1: load the output register.
- `halted` output, 1: high after HLT executes.
- `tstate` output, 3: current T-state, encoded 0..5 for T1..T6.

## Operation

- The T-state register advances T1→T2→…→T6→T1 on each rising edge while `halted` = 0.
- All strobes are a combinational decode of the registered `tstate`, `opcode` and `halted`. The datapath acts on the same edge that advances `tstate`.
- At most one bus driver (`*_en`) is asserted in any state.

Fetch, identical for all opcodes:
- T1: `pc_en`, `mar_ld`.
- T2: `pc_inc`.
- T3: `ram_en`, `ir_ld`.

Execute (opcode values are binary):
- LDA (0000): T4 `ir_en`, `mar_ld`. T5 `ram_en`, `a_ld`. T6 idle.
- ADD (0001): T4 `ir_en`, `mar_ld`. T5 `ram_en`, `b_ld`. T6 `alu_en`, `a_ld`, with `alu_sub` = 0.
- SUB (0010): same as ADD, but `alu_sub` = 1 throughout T6.
- OUT (1110): T4 `a_en`, `out_ld`. T5 and T6 idle.
- HLT (1111): T4 asserts no strobes, and `halted` is set on the edge ending T4.
- Any other opcode is a NOP: T4–T6 idle, and the cycle continues.

Halt behaviour:
- `halted` = 1 forces all strobes to 0.
- `tstate` freezes at T5 (the value after the edge ending T4).
- Only `rst` clears the halt.

## Timing

- Reset state: `tstate` = T1 and `halted` = 0. As a result, `pc_en` and `mar_ld` = 1 and all other strobes = 0 in the cycle after reset.
- `rst` takes priority over everything, in any state, including mid-execute and while halted. The next cycle is T1. No partial instruction completes.
- Every instruction takes exactly 6 clocks, including NOP, OUT and LDA.
- `pc_inc` is high for exactly one cycle per instruction. The PC therefore advances once per 6 clocks.
- PC wrap-around from 15 to 0 is handled by the PC and is invisible to this block.
- `opcode` must be stable from the edge ending T3 through the end of T6. It is ignored in T1–T3.
- `tstate` wraps from T6 to T1 with no idle cycle.

## Structure

- Package `sap1_pkg` holds:
  - Opcode constants `OP_LDA`, `OP_ADD`, `OP_SUB`, `OP_OUT`, `OP_HLT`.
  - The T-state encoding `T1`..`T6`.
  - A control-word bit-index enum shared with the datapath top.
- Sub-module `sap1_ring_counter` contains the `tstate` register with wrap at T6, a `freeze` input driven by `halted`, and synchronous `rst`.
- The top-level controller contains the halt flag and the combinational decode.

## Test plan

- **Reset fetch:** hold `rst` = 1 for 2 clocks, then release. Required: `tstate` = 0 with `pc_en` = `mar_ld` = 1, then `pc_inc` = 1 only at `tstate` = 1, then `ram_en` = `ir_ld` = 1 at `tstate` = 2.
- **LDA / ADD:** `opcode` = 0000. Required: T4 `ir_en` + `mar_ld`, T5 `ram_en` + `a_ld`, T6 no strobes. Then `opcode` = 0001. Required: T5 `b_ld`, and T6 `alu_en` + `a_ld` with `alu_sub` = 0.
- **SUB / OUT:** `opcode` = 0010. Required: T6 `alu_sub` = 1. Then `opcode` = 1110. Required: T4 `a_en` + `out_ld`, and T5–T6 idle.
- **HLT:** `opcode` = 1111. Required: `halted` = 1 after the T4 edge, `tstate` held at 4 for 20 clocks, all strobes 0. Then pulse `rst`. Required: `halted` = 0, `tstate` = 0, and fetch resumes.
- **Reset mid-operation:** assert `rst` during T5 of an ADD. Required: next cycle `tstate` = 0, with no `a_ld` or `alu_en` pulse.
- **Throughput:** run 16 consecutive NOPs (`opcode` = 0101). Required: exactly 16 `pc_inc` pulses in 96 clocks, each spaced 6 clocks apart.
